moving_average_window: RTL and testbench
========================================

# moving_average_window

Runtime-configurable boxcar moving-average filter for unsigned samples, with window length 2^P selected per sample stream. It is the parametrised successor to the fixed-window averager bank. Instead of one instance per window length plus an output mux, it uses a single circular sample buffer and a single running sum, sized for the largest window. It also adds clear, warm-up indication and clean restart on window change.

## Interface

Parameters:
- DATA_W, 10: sample width, unsigned.
- MAX_POW, 4: largest window exponent; buffer depth is 2^MAX_POW.
- POW_W, 3: width of the window-select field; must be at least clog2(MAX_POW+1).

Ports:
- clk, input, 1: single clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- data_i, input, DATA_W: sample in; valid when strobe_i is high.
- strobe_i, input, 1: one-cycle sample-valid pulse; may be asserted every cycle.
- win_pow_i, input, POW_W: window exponent P; window length is 2^P. Values above MAX_POW clamp to MAX_POW.
- clear_i, input, 1: synchronous flush of history.
- data_o, output, DATA_W: averaged result.
- strobe_o, output, 1: result-valid pulse.
- warm_o, output, 1: high once the current window holds 2^P real samples.

## Operation

State registers:
- wr_ptr: MAX_POW bits, wraps modulo 2^MAX_POW.
- fill: MAX_POW+1 bits, saturates at 2^P.
- sum: DATA_W+MAX_POW bits.
- pow_q: registered effective P.
- buffer: 2^MAX_POW x DATA_W.

Per accepted sample x (strobe_i high, clear_i low, no window change):
- old = buf[wr_ptr − 2^pow_q] if fill == 2^pow_q, else 0.
- sum ← sum + x − old.
- buf[wr_ptr] ← x; wr_ptr ← wr_ptr + 1; fill ← min(fill+1, 2^pow_q).
- data_o ← (sum + x − old) >> pow_q, truncating toward zero.
- strobe_o ← 1; warm_o ← (fill+1 ≥ 2^pow_q).

Warm-up:
- Missing samples count as zero, so the output ramps up.
- warm_o stays low until the window is full.

Window change (clamped win_pow_i ≠ pow_q), evaluated every cycle:
- pow_q ← new value; sum, fill and warm_o clear; wr_ptr is kept.
- If strobe_i is high in the same cycle, that sample is the first sample of the new window and produces an output normally.

clear_i:
- sum, fill, warm_o ← 0; wr_ptr ← 0; pow_q ← clamped win_pow_i.
- A strobe in the same cycle is dropped (clear wins) and strobe_o stays 0.

P = 0: pass-through with one cycle of latency; warm_o goes high on the first sample.

Arithmetic:
- sum never overflows, since its maximum is (2^DATA_W − 1)·2^MAX_POW.
- Subtraction is exact because old is always part of sum.

Buffer contents are not reset; the fill counter masks stale data.

## Timing

- Latency: strobe_i at edge n produces strobe_o/data_o at edge n+1. Throughput is one sample per cycle.
- strobe_o is high for exactly one cycle per accepted sample.
- data_o holds its last value between strobes.
- warm_o is a level: it changes only on an accepted sample, a clear, a window change, or reset.
- Reset values: data_o 0, strobe_o 0, warm_o 0, sum 0, fill 0, wr_ptr 0, pow_q 0.
- Reset asserted mid-stream: all registers go to reset values immediately (asynchronous); the first sample after release is treated as sample 1.

## Structure

Package moving_average_pkg:
- SUM_W function (DATA_W+MAX_POW).
- clamp_pow function.
- Default DATA_W/MAX_POW localparams shared with the top-level wrapper.

Sub-module moving_average_delay_line:
- Circular register buffer with write port and one combinational read at offset wr_ptr − 2^pow_q.
- Owns wr_ptr.

The top level holds sum, fill, pow_q, and the output registers.

## Test plan

- P=1, samples 10, 20, 30 back-to-back: data_o 5, 15, 25 on consecutive cycles; warm_o rises with the 15.
- P=4, constant 100 ×16: data_o 6, 12, 18 … 100 on the 16th sample, with warm_o high on the 16th only.
- P=4, 1023 ×20 then 0 ×16: data_o holds 1023 (no overflow), then steps down to 0 exactly on the 16th zero.
- P=2 warm at constant 40, then switch win_pow_i to 0 with strobe and data 7: next cycle data_o = 7 and warm_o = 1; a later switch to 2 with sample 8 gives data_o = 2 and warm_o = 0.
- clear_i and strobe_i in the same cycle with data 50: no strobe_o; the next sample 40 at P=1 gives data_o = 20.
- rst_n pulsed low mid-stream at P=3: all outputs go to 0 asynchronously; after release, sample 80 gives data_o = 10 and warm_o = 0.
- win_pow_i = 7 with MAX_POW = 4: behaves as P = 4.

Source files
------------

// File: rtl/moving_average_pkg.sv
// Shared constants and helpers for the moving-average window filter.
//   sum_w     : running-sum width for a given sample width and max window exponent
//   clamp_pow : limit a requested window exponent to the buffer's maximum
package moving_average_pkg;

  localparam int DEFAULT_DATA_W  = 10;
  localparam int DEFAULT_MAX_POW = 4;

  // Wide enough for 2^max_pow full-scale samples, so the sum cannot overflow.
  function automatic int sum_w(input int data_w, input int max_pow);
    return data_w + max_pow;
  endfunction

  function automatic int clamp_pow(input int pow, input int max_pow);
    return (pow > max_pow) ? max_pow : pow;
  endfunction

endpackage

// File: rtl/moving_average_delay_line.sv
// Circular sample history for the moving-average filter.
// Write port at wr_ptr; one combinational read of the sample leaving the
// window, i.e. the one written 2^pow samples ago (offset wr_ptr - 2^pow).
// Ports:
//   clk, rst_n   : clock, async active-low reset (wr_ptr only)
//   wr_en        : store wr_data at wr_ptr and advance
//   clr          : synchronous pointer reset
//   wr_data      : sample to store
//   pow          : current window exponent
//   rd_data      : oldest sample of the current window
module moving_average_delay_line
  import moving_average_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int MAX_POW = DEFAULT_MAX_POW,
  parameter int POW_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [POW_W-1:0]  pow,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** MAX_POW;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [MAX_POW-1:0] wr_ptr;
  logic [MAX_POW-1:0] rd_addr;
  logic [MAX_POW:0]   span;

  // With pow == MAX_POW the span wraps to zero: the slot about to be
  // overwritten is exactly the oldest sample.
  always_comb begin
    span    = (MAX_POW+1)'(1) << pow;
    rd_addr = wr_ptr - span[MAX_POW-1:0];
    rd_data = mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     wr_ptr <= '0;
    else if (clr)   wr_ptr <= '0;
    else if (wr_en) wr_ptr <= wr_ptr + 1'b1;
  end

  // History is not reset; the fill counter upstream masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/moving_average_window.sv
// Boxcar moving average of unsigned samples over a runtime window of 2^P.
// Single running sum plus circular history sized for 2^MAX_POW samples.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   data_i     : sample, valid with strobe_i
//   strobe_i   : sample-valid pulse
//   win_pow_i  : window exponent P (clamped to MAX_POW)
//   clear_i    : synchronous history flush (drops a same-cycle sample)
//   data_o     : average, held between strobes
//   strobe_o   : one-cycle result-valid pulse
//   warm_o     : window holds 2^P real samples
module moving_average_window
  import moving_average_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int MAX_POW = DEFAULT_MAX_POW,
  parameter int POW_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_i,
  input  logic              strobe_i,
  input  logic [POW_W-1:0]  win_pow_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] data_o,
  output logic              strobe_o,
  output logic              warm_o
);

  localparam int SW = sum_w(DATA_W, MAX_POW);

  logic [POW_W-1:0]  pow_q, eff_pow, pow_use;
  logic [SW-1:0]     sum, base_sum, old_ext, sum_nxt;
  logic [MAX_POW:0]  fill, base_fill, full, fill_nxt;
  logic [DATA_W-1:0] rd_data;
  logic              win_chg, accept, warm_nxt;

  moving_average_delay_line #(
    .DATA_W (DATA_W),
    .MAX_POW(MAX_POW),
    .POW_W  (POW_W)
  ) u_dly (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (accept),
    .clr    (clear_i),
    .wr_data(data_i),
    .pow    (pow_q),
    .rd_data(rd_data)
  );

  // On a window change the sample (if any) starts a fresh window, so the
  // arithmetic runs from an empty sum/fill under the new exponent.
  always_comb begin
    eff_pow   = POW_W'(clamp_pow(int'(win_pow_i), MAX_POW));
    win_chg   = (eff_pow != pow_q);
    accept    = strobe_i && !clear_i;
    pow_use   = win_chg ? eff_pow : pow_q;
    base_sum  = win_chg ? '0 : sum;
    base_fill = win_chg ? '0 : fill;
    full      = (MAX_POW+1)'(1) << pow_use;
    // Missing samples count as zero until the window is full.
    old_ext   = (base_fill == full) ? SW'(rd_data) : '0;
    sum_nxt   = base_sum + SW'(data_i) - old_ext;
    fill_nxt  = (base_fill == full) ? full : base_fill + 1'b1;
    warm_nxt  = ((base_fill + 1'b1) >= full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum      <= '0;
      fill     <= '0;
      pow_q    <= '0;
      data_o   <= '0;
      strobe_o <= 1'b0;
      warm_o   <= 1'b0;
    end else if (clear_i) begin
      sum      <= '0;
      fill     <= '0;
      pow_q    <= eff_pow;
      strobe_o <= 1'b0;
      warm_o   <= 1'b0;
    end else begin
      strobe_o <= accept;
      pow_q    <= eff_pow;
      if (accept) begin
        sum    <= sum_nxt;
        fill   <= fill_nxt;
        warm_o <= warm_nxt;
        data_o <= DATA_W'(sum_nxt >> pow_use);
      end else if (win_chg) begin
        sum    <= '0;
        fill   <= '0;
        warm_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_window.sv
module tb_moving_average_window;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] data_i;
  logic       strobe_i;
  logic [2:0] win_pow_i;
  logic       clear_i;
  logic [9:0] data_o;
  logic       strobe_o;
  logic       warm_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  moving_average_window #(.DATA_W(10), .MAX_POW(4), .POW_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .strobe_i (strobe_i),
    .win_pow_i(win_pow_i),
    .clear_i  (clear_i),
    .data_o   (data_o),
    .strobe_o (strobe_o),
    .warm_o   (warm_o)
  );

  typedef struct {
    string      name;
    logic       clr;
    logic       stb;
    logic [2:0] pow;
    logic [9:0] din;
    logic [9:0] exp_data;
    logic       exp_stb;
    logic       exp_warm;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic clr, input logic stb,
                              input logic [2:0] pow, input int din, input int ed,
                              input logic es, input logic ew);
    vec_t v;
    v.name = name; v.clr = clr; v.stb = stb; v.pow = pow; v.din = 10'(din);
    v.exp_data = 10'(ed); v.exp_stb = es; v.exp_warm = ew;
    return v;
  endfunction

  // Drive one cycle, then sample 1 time unit after the active edge.
  task automatic apply(input vec_t v);
    clear_i = v.clr; strobe_i = v.stb; win_pow_i = v.pow; data_i = v.din;
    @(posedge clk);
    #1;
    check({v.name, ".stb"},  int'(strobe_o), int'(v.exp_stb));
    check({v.name, ".data"}, int'(data_o),   int'(v.exp_data));
    check({v.name, ".warm"}, int'(warm_o),   int'(v.exp_warm));
  endtask

  initial begin
    rst_n = 1'b0; data_i = '0; strobe_i = 1'b0; win_pow_i = '0; clear_i = 1'b0;

    // P=1 ramp
    vecs.push_back(mk("p1_s1", 0, 1, 1, 10, 5, 1, 0));
    vecs.push_back(mk("p1_s2", 0, 1, 1, 20, 15, 1, 1));
    vecs.push_back(mk("p1_s3", 0, 1, 1, 30, 25, 1, 1));
    vecs.push_back(mk("p1_idle", 0, 0, 1, 0, 25, 0, 1));
    // P=4 constant 100: 100*k/16 truncated
    begin
      int ramp[16] = '{6, 12, 18, 25, 31, 37, 43, 50, 56, 62, 68, 75, 81, 87, 93, 100};
      for (int k = 0; k < 16; k++)
        vecs.push_back(mk($sformatf("p4_c100_%0d", k + 1), 0, 1, 4, 100, ramp[k], 1, k == 15));
    end
    // Flush, then full-scale: 1023*min(k,16)/16, then zeros stepping down
    vecs.push_back(mk("p4_clear", 1, 0, 4, 0, 100, 0, 0));
    for (int k = 1; k <= 20; k++)
      vecs.push_back(mk($sformatf("p4_max_%0d", k), 0, 1, 4, 1023,
                        (1023 * (k > 16 ? 16 : k)) / 16, 1, k >= 16));
    for (int k = 1; k <= 16; k++)
      vecs.push_back(mk($sformatf("p4_zero_%0d", k), 0, 1, 4, 0, (1023 * (16 - k)) / 16, 1, 1));
    // P=2 warm at 40, then window changes carrying a sample
    vecs.push_back(mk("p2_s1", 0, 1, 2, 40, 10, 1, 0));
    vecs.push_back(mk("p2_s2", 0, 1, 2, 40, 20, 1, 0));
    vecs.push_back(mk("p2_s3", 0, 1, 2, 40, 30, 1, 0));
    vecs.push_back(mk("p2_s4", 0, 1, 2, 40, 40, 1, 1));
    vecs.push_back(mk("chg_p0", 0, 1, 0, 7, 7, 1, 1));
    vecs.push_back(mk("chg_p2", 0, 1, 2, 8, 2, 1, 0));
    // clear wins over a same-cycle strobe
    vecs.push_back(mk("clr_stb", 1, 1, 1, 50, 2, 0, 0));
    vecs.push_back(mk("after_clr", 0, 1, 1, 40, 20, 1, 0));
    // Out-of-range exponent behaves as 4, and is not a repeated window change
    vecs.push_back(mk("clamp_s1", 0, 1, 7, 160, 10, 1, 0));
    vecs.push_back(mk("clamp_s2", 0, 1, 7, 160, 20, 1, 0));
    vecs.push_back(mk("clamp_eq4", 0, 1, 4, 160, 30, 1, 0));
    // Window change with no sample: holds data, drops warm
    vecs.push_back(mk("chg_nostb", 0, 0, 3, 0, 30, 0, 0));
    vecs.push_back(mk("p3_s1", 0, 1, 3, 80, 10, 1, 0));
    vecs.push_back(mk("p3_s2", 0, 1, 3, 80, 20, 1, 0));
    vecs.push_back(mk("p3_s3", 0, 1, 3, 80, 30, 1, 0));

    repeat (2) @(posedge clk);
    #1;
    check("reset.data", int'(data_o), 0);
    check("reset.stb",  int'(strobe_o), 0);
    check("reset.warm", int'(warm_o), 0);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset mid-stream at P=3 (warm_o forced high first via P=0)
    apply(mk("pre_rst_p0", 0, 1, 0, 9, 9, 1, 1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.data", int'(data_o), 0);
    check("async_rst.stb",  int'(strobe_o), 0);
    check("async_rst.warm", int'(warm_o), 0);
    strobe_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    apply(mk("post_rst_s1", 0, 1, 3, 80, 10, 1, 0));
    apply(mk("post_rst_s2", 0, 1, 3, 80, 20, 1, 0));
    // Pass-through at P=0
    apply(mk("p0_s1", 0, 1, 0, 5, 5, 1, 1));
    apply(mk("p0_s2", 0, 1, 0, 9, 9, 1, 1));
    apply(mk("p0_idle", 0, 0, 0, 0, 9, 0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
